prog_mem: RTL

Parametrised, reloadable instruction memory for NECPU. It replaces the fixed case-table ROM with a synchronous RAM. The RAM has a registered fetch port for the CPU and a byte-stream load port, so a host (e.g. the UART bootloader) can download an assembler-produced program without resynthesis. It sits between the PC/fetch stage and the program loader.

---
 rtl/prog_mem.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_mem.sv
// prog_mem - reloadable instruction memory for NECPU.
//
// A synchronous RAM with a registered fetch port for the CPU and a byte-stream
// load port for a host loader (e.g. the UART bootloader). Bytes are assembled
// into INST_WIDTH-bit words, in the order chosen by BIG_ENDIAN, and written
// word by word starting at address 0.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset (memory contents survive)
//   address         fetch word address
//   fetch_en        fetch request this cycle
//   inst            registered fetched instruction
//   inst_valid      inst was updated by a fetch accepted last cycle
//   load_start      begin (or restart) a load at word 0
//   load_len        number of words to load, sampled with load_start
//   load_byte       load data byte
//   load_byte_valid load_byte is valid this cycle
//   busy            load in progress
//   load_done       one-cycle pulse when a load completes
module prog_mem #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter bit BIG_ENDIAN = 1'b1,
  localparam int LEN_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  fetch_en,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  load_start,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic [7:0]            load_byte,
  input  logic                  load_byte_valid,
  output logic                  busy,
  output logic                  load_done
);

  localparam int BYTES     = INST_WIDTH / 8;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  // Comparison width wide enough for both the address and DEPTH itself.
  localparam int CMP_W     = (ADDR_WIDTH > PTR_W + 1) ? ADDR_WIDTH : PTR_W + 1;
  localparam int TOP_SHIFT = INST_WIDTH - 8;

  localparam logic [LEN_WIDTH-1:0] DEPTH_LEN = LEN_WIDTH'(DEPTH);
  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(BYTES - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Shift one byte into the assembly word; the first byte ends up at the
  // top for big-endian and at the bottom for little-endian.
  function automatic logic [INST_WIDTH-1:0] assemble(
    input logic [INST_WIDTH-1:0] acc,
    input logic [7:0]            b
  );
    logic [INST_WIDTH-1:0] b_ext;
    b_ext = INST_WIDTH'(b);
    if (BIG_ENDIAN) begin
      assemble = (acc << 4'd8) | b_ext;
    end else begin
      assemble = (acc >> 4'd8) | (b_ext << TOP_SHIFT);
    end
  endfunction

  // Requested length clamped to the memory depth.
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] l);
    if (l > DEPTH_LEN) begin
      clamp_len = DEPTH_LEN;
    end else begin
      clamp_len = l;
    end
  endfunction

  logic [INST_WIDTH-1:0] mem [DEPTH];

  state_t                state_r;
  logic [INST_WIDTH-1:0] inst_r;
  logic                  inst_valid_r;
  logic                  busy_r;
  logic                  load_done_r;
  logic [PTR_W-1:0]      ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [INST_WIDTH-1:0] asm_r;

  logic [CMP_W-1:0]      addr_ext_s;
  logic                  in_range_s;
  logic [LEN_WIDTH-1:0]  len_sel_s;
  logic                  last_byte_s;
  logic                  last_word_s;
  logic                  wr_en_s;
  logic [INST_WIDTH-1:0] wr_data_s;

  // Decode fetch range, load length and the word-complete write strobe.
  always_comb begin
    addr_ext_s  = CMP_W'(address);
    in_range_s  = (addr_ext_s < CMP_W'(DEPTH));
    len_sel_s   = clamp_len(load_len);
    last_byte_s = (cnt_r == LAST_CNT);
    last_word_s = ({1'b0, ptr_r} == (len_r - LEN_WIDTH'(1)));
    wr_data_s   = assemble(asm_r, load_byte);
    // load_start has priority over a byte in the same cycle, so it blocks the write.
    if ((state_r == ST_LOAD) && !load_start && load_byte_valid && last_byte_s && !rst) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Memory array write port; deliberately not reset so programs survive rst.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[ptr_r] <= wr_data_s;
    end
  end

  // Control FSM, fetch register and load bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_RUN;
      inst_r       <= '0;
      inst_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      load_done_r  <= 1'b0;
      ptr_r        <= '0;
      cnt_r        <= '0;
      len_r        <= '0;
      asm_r        <= '0;
    end else begin
      load_done_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (fetch_en) begin
            inst_valid_r <= 1'b1;
            if (in_range_s) begin
              inst_r <= mem[addr_ext_s[PTR_W-1:0]];
            end else begin
              inst_r <= '0;
            end
          end else begin
            inst_valid_r <= 1'b0;
          end
          if (load_start) begin
            len_r <= len_sel_s;
            ptr_r <= '0;
            cnt_r <= '0;
            asm_r <= '0;
            if (len_sel_s == LEN_WIDTH'(0)) begin
              // Zero-length load completes immediately without leaving RUN.
              load_done_r <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
              busy_r  <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          inst_valid_r <= 1'b0;
          if (load_start) begin
            // Restart: partial word dropped, already written words kept.
            len_r <= len_sel_s;
            ptr_r <= '0;
            cnt_r <= '0;
            asm_r <= '0;
            if (len_sel_s == LEN_WIDTH'(0)) begin
              state_r     <= ST_RUN;
              busy_r      <= 1'b0;
              load_done_r <= 1'b1;
            end
          end else if (load_byte_valid) begin
            asm_r <= wr_data_s;
            if (last_byte_s) begin
              cnt_r <= '0;
              ptr_r <= ptr_r + PTR_W'(1);
              if (last_word_s) begin
                state_r     <= ST_RUN;
                busy_r      <= 1'b0;
                load_done_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end

        default: begin
          state_r      <= ST_RUN;
          busy_r       <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign inst       = inst_r;
  assign inst_valid = inst_valid_r;
  assign busy       = busy_r;
  assign load_done  = load_done_r;

endmodule
